dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller for the MEM stage of the five-stage pipeline. It serves word loads and stores from the MEM stage and fetches or evicts 4-word lines over a single-beat request/acknowledge memory port. It drives `cache_stall`, the CacheStall input of the hazard unit, which freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while a miss is serviced.

---
 rtl/dcache_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Lines hold four 32-bit words; misses are serviced over a single-beat req/ack port.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cache_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned TagW  = ADDR_W - INDEX_W - 4;
    localparam int unsigned Lines = 2 ** INDEX_W;

    typedef enum logic [1:0] {StIdle, StWb, StRefill} state_e;

    state_e state_q, state_d;
    logic [1:0] beat_q, beat_d, beat_nxt;

    logic [Lines-1:0] valid_q, valid_d;
    logic [Lines-1:0] dirty_q, dirty_d;
    logic [TagW-1:0]  tag_q  [Lines];
    logic [31:0]      data_q [Lines][4];

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [TagW-1:0]    req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [1:0]         req_off;
    logic               cpu_req;
    logic               hit;
    logic               ack;
    logic               data_we;
    logic [1:0]         data_woff;
    logic [31:0]        data_wdata;
    logic               tag_we;
    logic               unused_addr_bits;

    assign req_tag          = cpu_addr[ADDR_W-1:INDEX_W+4];
    assign req_idx          = cpu_addr[INDEX_W+3:4];
    assign req_off          = cpu_addr[3:2];
    assign unused_addr_bits = ^cpu_addr[1:0];
    assign cpu_req          = cpu_rd | cpu_wr;
    assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ack              = mem_req_q & mem_ack;
    assign beat_nxt         = beat_q + 2'd1;

    assign cpu_rdata = data_q[req_idx][req_off];
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next-state, line bookkeeping and next memory beat.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_we     = 1'b0;
        data_woff   = req_off;
        data_wdata  = cpu_wdata;
        tag_we      = 1'b0;
        cache_stall = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (hit) begin
                        // A simultaneous rd/wr is a store.
                        if (cpu_wr) begin
                            data_we          = 1'b1;
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else begin
                        cache_stall      = 1'b1;
                        beat_d           = 2'd0;
                        mem_req_d        = 1'b1;
                        valid_d[req_idx] = 1'b0;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_d     = StWb;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_q[req_idx], req_idx, 2'd0, 2'b00};
                            mem_wdata_d = data_q[req_idx][0];
                        end else begin
                            state_d    = StRefill;
                            mem_we_d   = 1'b0;
                            mem_addr_d = {req_tag, req_idx, 2'd0, 2'b00};
                        end
                    end
                end
            end
            StWb: begin
                cache_stall = 1'b1;
                if (ack) begin
                    if (beat_q == 2'd3) begin
                        // Writeback done: launch the first refill beat on the same edge.
                        dirty_d[req_idx] = 1'b0;
                        state_d          = StRefill;
                        beat_d           = 2'd0;
                        mem_we_d         = 1'b0;
                        mem_addr_d       = {req_tag, req_idx, 2'd0, 2'b00};
                    end else begin
                        beat_d      = beat_nxt;
                        mem_addr_d  = {tag_q[req_idx], req_idx, beat_nxt, 2'b00};
                        mem_wdata_d = data_q[req_idx][beat_nxt];
                    end
                end
            end
            StRefill: begin
                cache_stall = 1'b1;
                if (ack) begin
                    data_we    = 1'b1;
                    data_woff  = beat_q;
                    data_wdata = mem_rdata;
                    if (beat_q == 2'd3) begin
                        tag_we           = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        state_d          = StIdle;
                        beat_d           = 2'd0;
                        mem_req_d        = 1'b0;
                        mem_we_d         = 1'b0;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = {req_tag, req_idx, beat_nxt, 2'b00};
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Control state, line status bits and registered memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beat_q      <= 2'd0;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their contents.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[req_idx][data_woff] <= data_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        miss_pend_q, miss_pend_d;
    logic        lookup;

    assign lookup   = (state_q == StIdle) && cpu_req;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // A hit only counts if the held request did not miss first.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        miss_pend_d = miss_pend_q;
        if (lookup && hit) begin
            if (!miss_pend_q) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            miss_pend_d = 1'b0;
        end else if (lookup) begin
            miss_cnt_d  = miss_cnt_q + 32'd1;
            miss_pend_d = 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            miss_pend_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            miss_pend_q <= miss_pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a behavioural cache/memory model predicts memory beats,
// stall lengths and load data; monitors compare them as the DUT presents them.
module tb_dcache_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        int          stall;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl #(.INDEX_W(6), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cache_stall (cache_stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_delay = 0;

    beat_t exp_beat[$];
    resp_t exp_resp[$];

    // Reference model: cache state plus its own view of main memory.
    logic        m_valid [64];
    logic        m_dirty [64];
    logic [21:0] m_tag   [64];
    logic [31:0] m_data  [64][4];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dut_mem [logic [31:0]];
    int          m_hits   = 0;
    int          m_misses = 0;

    function automatic logic [31:0] init_word(input logic [31:0] addr);
        if (addr >= 32'h40 && addr < 32'h50) return 32'h11 * ((addr - 32'h40) / 4 + 1);
        return (addr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] addr);
        if (ref_mem.exists(addr >> 2)) return ref_mem[addr >> 2];
        return init_word(addr);
    endfunction

    function automatic logic [31:0] dut_rd(input logic [31:0] addr);
        if (dut_mem.exists(addr >> 2)) return dut_mem[addr >> 2];
        return init_word(addr);
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Predict the full effect of one CPU access and queue the expected observations.
    function automatic void ref_access(input logic [31:0] addr, input bit wr,
                                       input logic [31:0] wd, input int d);
        logic [5:0]  idx = addr[9:4];
        logic [1:0]  off = addr[3:2];
        logic [21:0] tag = addr[31:10];
        int          stall = 0;
        beat_t       b;
        resp_t       r;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            m_misses++;
            stall = 1;
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int k = 0; k < 4; k++) begin
                    b.addr = {m_tag[idx], idx, 2'(k), 2'b00};
                    b.we   = 1'b1;
                    b.data = m_data[idx][k];
                    ref_mem[b.addr >> 2] = b.data;
                    exp_beat.push_back(b);
                    stall += d + 1;
                end
            end
            for (int k = 0; k < 4; k++) begin
                b.addr = {tag, idx, 2'(k), 2'b00};
                b.we   = 1'b0;
                b.data = ref_rd(b.addr);
                m_data[idx][k] = b.data;
                exp_beat.push_back(b);
                stall += d + 1;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end else begin
            m_hits++;
        end
        if (wr) begin
            m_data[idx][off] = wd;
            m_dirty[idx]     = 1'b1;
        end
        r.is_load = !wr;
        r.rdata   = m_data[idx][off];
        r.stall   = stall;
        exp_resp.push_back(r);
    endfunction

    // Memory responder: acks after ack_delay waiting cycles, plus stray acks while idle.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) cnt = 0;
            mem_ack = 1'b0;
            if (!rst_n) begin
                cnt = 0;
                continue;
            end
            if (mem_req) begin
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) dut_mem[mem_addr >> 2] = mem_wdata;
                    else mem_rdata = dut_rd(mem_addr);
                end else begin
                    cnt++;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: compares memory beats, held beat addresses, stall lengths and load data.
    initial begin : monitor
        int          stall_cnt;
        bit          waiting;
        logic [31:0] hold_addr;
        beat_t       b;
        resp_t       r;
        stall_cnt = 0;
        waiting   = 1'b0;
        hold_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_cnt = 0;
                waiting   = 1'b0;
                continue;
            end
            if (mem_req) begin
                if (waiting) check("beat_hold_addr", mem_addr, hold_addr);
                if (mem_ack) begin
                    waiting = 1'b0;
                    if (exp_beat.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got beat at %h, required none", mem_addr);
                    end else begin
                        b = exp_beat.pop_front();
                        check("beat_addr", mem_addr, b.addr);
                        check("beat_we", 32'(mem_we), 32'(b.we));
                        if (b.we) check("beat_wdata", mem_wdata, b.data);
                    end
                end else begin
                    waiting   = 1'b1;
                    hold_addr = mem_addr;
                end
            end else begin
                waiting = 1'b0;
            end
            if (cpu_rd || cpu_wr) begin
                if (cache_stall) begin
                    stall_cnt++;
                end else if (exp_resp.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_completion: got completion, required none");
                end else begin
                    r = exp_resp.pop_front();
                    check("stall_cycles", 32'(stall_cnt), 32'(r.stall));
                    if (r.is_load) check("load_data", cpu_rdata, r.rdata);
                    stall_cnt = 0;
                end
            end else begin
                check("idle_stall", 32'(cache_stall), 32'd0);
                check("idle_mem_req", 32'(mem_req), 32'd0);
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wd, input int d);
        bit done;
        done      = 1'b0;
        ack_delay = d;
        ref_access(addr, wr, wd, d);
        cpu_addr  = addr;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_wdata = wd;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!cache_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL req_timeout: got stall still high, required completion for %h", addr);
        end
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no finish, required end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit got;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_stall_idle", 32'(cache_stall), 32'd0);
        cpu_rd   = 1'b1;
        cpu_addr = 32'h40;
        #1;
        check("rst_stall_req", 32'(cache_stall), 32'd1);
        cpu_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Clean miss, hit, dirty eviction, slow memory.
        do_req(32'h0000_0040, 1'b1, 1'b0, 32'h0, 0);
        do_req(32'h0000_0048, 1'b1, 1'b0, 32'h0, 0);
        do_req(32'h0000_0044, 1'b0, 1'b1, 32'hDEAD_BEEF, 0);
        do_req(32'h0000_0444, 1'b1, 1'b0, 32'h0, 0);
        idle(2);
        do_req(32'h0000_0040, 1'b1, 1'b0, 32'h0, 3);
        do_req(32'h0000_0044, 1'b1, 1'b0, 32'h0, 0);

        // Reset while the third refill beat is outstanding.
        ack_delay = 1;
        ref_access(32'h0000_0080, 1'b0, 32'h0, 1);
        cpu_addr = 32'h0000_0080;
        cpu_rd   = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (exp_beat.size() == 2) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            $display("FAIL reset_beat_wait: got no third beat, required refill progress");
        end
        #2;
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_mem_addr", mem_addr, 32'd0);
        check("rst_stall_held_req", 32'(cache_stall), 32'd1);
        exp_beat.delete();
        exp_resp.delete();
        model_reset();
        cpu_rd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        do_req(32'h0000_0080, 1'b1, 1'b0, 32'h0, 0);
        do_req(32'h0000_0084, 1'b1, 1'b0, 32'h0, 0);

        // Randomized traffic over a few conflicting tags and indices.
        for (int i = 0; i < 150; i++) begin
            logic [21:0] tag;
            logic [5:0]  idx;
            logic [3:0]  lo;
            logic [31:0] addr;
            int          op;
            int          d;
            tag  = ($urandom_range(0, 5) == 0) ? 22'($urandom) : 22'($urandom_range(0, 3));
            idx  = 6'($urandom_range(0, 5));
            lo   = 4'($urandom);
            addr = {tag, idx, lo};
            op   = $urandom_range(0, 2);
            d    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_req(addr, op != 1, op != 0, $urandom, d);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        check("beat_queue_empty", 32'(exp_beat.size()), 32'd0);
        check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
`ifdef DCACHE_STATS_EN
        check("hit_cnt", hit_cnt, 32'(m_hits));
        check("miss_cnt", miss_cnt, 32'(m_misses));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
